addr_gen: RTL and testbench
===========================

Name: addr_gen

Overview:
Parametrised successor to the team's simple enable-driven address counter. Generates a programmable address sequence: base, stride, beat count, up/down direction, and one-shot or wrap-around mode. Uses a start/busy/done handshake so a controller FSM can launch a sweep and wait for completion. Sits between a control FSM and memory/ROM address ports.

Parameters:
- ADDR_W, 8: width of address, base and stride.
- CNT_W, 8: width of beat count / limit.
- STEP_W, 4: width of stride input (zero-extended to ADDR_W).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  launch request; sampled only in IDLE.
- cfg_base  in  ADDR_W  first address of sequence.
- cfg_limit  in  CNT_W  number of beats per pass; 0 is illegal.
- cfg_step  in  STEP_W  stride magnitude; 0 is legal (address holds).
- cfg_down  in  1  1 = decrement by stride, 0 = increment.
- cfg_wrap  in  1  1 = restart at base after last beat, 0 = one-shot.
- cnt_en  in  1  advance one beat when high in RUN.
- stop  in  1  abort current sequence.
- address  out  ADDR_W  current address.
- beat  out  CNT_W  index of current beat within pass.
- last  out  1  current beat is final beat of pass (cout equivalent).
- busy  out  1  high in RUN.
- done  out  1  one-cycle pulse on one-shot completion.
- wrapped  out  1  one-cycle pulse when a wrap-mode pass restarts.
- err  out  1  one-cycle pulse when start is rejected.

Behaviour:
- Reset: state=IDLE; address=0, beat=0; busy, done, wrapped, err=0; config registers=0.
- States: IDLE, RUN, DONE. Registered one-hot or binary, implementer's choice.
- IDLE:
  - start with cfg_limit != 0: latch all cfg_* inputs; address<=cfg_base, beat<=0; go RUN next edge.
  - start with cfg_limit == 0: stay IDLE; err=1 for one cycle; address/beat unchanged.
  - address and beat hold their last values in IDLE.
- RUN:
  - busy=1. address is valid from the first RUN cycle, one cycle after start.
  - last = (beat == limit_q-1), combinational from registers.
  - cnt_en & !last: beat<=beat+1; address<=address±step_q, modulo 2^ADDR_W with natural wrap and no saturation.
  - cnt_en & last & wrap_q: address<=base_q, beat<=0, wrapped=1 for one cycle, stay RUN.
  - cnt_en & last & !wrap_q: go DONE; address/beat hold final values.
  - !cnt_en: all registers hold.
- DONE:
  - done=1 for exactly one cycle, then IDLE.
  - start during DONE is ignored (not queued).
- stop: in RUN, go IDLE at next edge with no done and no wrapped; address/beat hold. stop has priority over cnt_en in the same cycle. Ignored in IDLE and DONE.
- start while busy: ignored. Config inputs are only sampled at an accepted start, so mid-run changes have no effect.
- limit_q == 1: last is high on the first RUN cycle; the first cnt_en completes the pass.
- Reset asserted mid-operation: immediate return to reset values; no done pulse.
- All outputs are registered except last and busy, which decode state and registers only.

Decomposition:
- Package addr_gen_pkg holds:
  - state enum {IDLE, RUN, DONE};
  - localparam defaults for ADDR_W, CNT_W, STEP_W.
- One sub-module is natural: beat_counter. It is a CNT_W-bit up-counter with clear, enable and terminal flag (beat == limit-1), which generalises the legacy counter. The stride adder/subtractor and the FSM stay in addr_gen.

Test Plan:
- One-shot up: base=0x10, step=2, limit=4, wrap=0; cnt_en held high → address 0x10, 0x12, 0x14, 0x16; last high at 0x16; done pulses one cycle later; busy low after.
- Down with modulo wrap: base=0x01, step=3, down=1, limit=3 → address 0x01, 0xFE, 0xFB; done pulses once.
- Wrap mode plus stop: base=0x20, step=1, limit=2, wrap=1 → 0x20, 0x21, 0x20, 0x21 with a wrapped pulse on each restart; stop and cnt_en together → IDLE next edge, no done, address holds.
- Illegal and ignored starts: start with limit=0 → err pulse, stays IDLE. start during RUN, or with changed cfg_* mid-run → sequence unaffected.
- Gapped enable and limit=1: cnt_en toggling 1/0 → address advances only on enabled cycles. limit=1 → last high immediately; a single cnt_en yields done.
- Async reset mid-RUN at beat 2: outputs go to 0 and state to IDLE without waiting for a clock edge; no done pulse; a new start after reset release behaves normally.

Source files
------------

// File: rtl/addr_gen_pkg.sv
// Shared types and default widths for the programmable address generator.
package addr_gen_pkg;

  localparam int ADDR_W_DEF = 8;
  localparam int CNT_W_DEF  = 8;
  localparam int STEP_W_DEF = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

endpackage

// File: rtl/addr_gen_beat_counter.sv
// Beat index counter with clear, enable and terminal flag (beat == limit-1).
module beat_counter #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr_i,
  input  logic             en_i,
  input  logic [CNT_W-1:0] limit_i,
  output logic [CNT_W-1:0] beat_o,
  output logic             term_o
);

  logic [CNT_W-1:0] beat_q, beat_d;

  // Clear wins over enable so a wrap restart lands exactly on beat 0.
  always_comb begin
    beat_d = beat_q;
    if (clr_i)     beat_d = '0;
    else if (en_i) beat_d = beat_q + CNT_W'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) beat_q <= '0;
    else     beat_q <= beat_d;
  end

  assign beat_o = beat_q;
  assign term_o = (beat_q == (limit_i - CNT_W'(1)));

endmodule

// File: rtl/addr_gen.sv
// Programmable address sequencer: base/stride/beat-count sweep, up or down,
// one-shot or wrap-around, launched with a start/busy/done handshake.
module addr_gen
  import addr_gen_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int CNT_W  = CNT_W_DEF,
  parameter int STEP_W = STEP_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] cfg_base,
  input  logic [CNT_W-1:0]  cfg_limit,
  input  logic [STEP_W-1:0] cfg_step,
  input  logic              cfg_down,
  input  logic              cfg_wrap,
  input  logic              cnt_en,
  input  logic              stop,
  output logic [ADDR_W-1:0] address,
  output logic [CNT_W-1:0]  beat,
  output logic              last,
  output logic              busy,
  output logic              done,
  output logic              wrapped,
  output logic              err,
  output state_e            dbg_state
);

  // Handshake: start is accepted only in IDLE with a nonzero limit; busy is
  // high for every RUN cycle starting the cycle after acceptance; done pulses
  // for one cycle after a one-shot pass ends, and start is ignored until IDLE.
  state_e state_q, state_d;

  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [ADDR_W-1:0] base_q, step_q;
  logic [CNT_W-1:0]  limit_q;
  logic              down_q, wrap_q;
  logic              done_q, wrapped_q, err_q;

  logic accept, reject, advance, restart, finish;
  logic term;

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    accept  = 1'b0;
    reject  = 1'b0;
    advance = 1'b0;
    restart = 1'b0;
    finish  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          if (cfg_limit != '0) begin
            accept  = 1'b1;
            addr_d  = cfg_base;
            state_d = RUN;
          end else begin
            reject = 1'b1;
          end
        end
      end
      RUN: begin
        // stop outranks cnt_en, so an abort on the last beat never restarts.
        if (stop) begin
          state_d = IDLE;
        end else if (cnt_en) begin
          if (!term) begin
            advance = 1'b1;
            addr_d  = down_q ? (addr_q - step_q) : (addr_q + step_q);
          end else if (wrap_q) begin
            restart = 1'b1;
            addr_d  = base_q;
          end else begin
            finish  = 1'b1;
            state_d = DONE;
          end
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      addr_q    <= '0;
      base_q    <= '0;
      step_q    <= '0;
      limit_q   <= '0;
      down_q    <= 1'b0;
      wrap_q    <= 1'b0;
      done_q    <= 1'b0;
      wrapped_q <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      done_q    <= finish;
      wrapped_q <= restart;
      err_q     <= reject;
      if (accept) begin
        base_q  <= cfg_base;
        step_q  <= ADDR_W'(cfg_step);
        limit_q <= cfg_limit;
        down_q  <= cfg_down;
        wrap_q  <= cfg_wrap;
      end
    end
  end

  beat_counter #(.CNT_W(CNT_W)) u_beat (
    .clk     (clk),
    .rst     (rst),
    .clr_i   (accept | restart),
    .en_i    (advance),
    .limit_i (limit_q),
    .beat_o  (beat),
    .term_o  (term)
  );

  assign address   = addr_q;
  assign busy      = (state_q == RUN);
  assign last      = (state_q == RUN) && term;
  assign done      = done_q;
  assign wrapped   = wrapped_q;
  assign err       = err_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_addr_gen.sv
// Self-checking bench for addr_gen: directed plan cases plus randomized sweeps
// checked against a closed-form address model.
module tb_addr_gen;
  import addr_gen_pkg::*;

  localparam int AW = 8;
  localparam int CW = 8;
  localparam int SW = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic [AW-1:0] cfg_base = '0;
  logic [CW-1:0] cfg_limit = '0;
  logic [SW-1:0] cfg_step = '0;
  logic          cfg_down = 1'b0;
  logic          cfg_wrap = 1'b0;
  logic          cnt_en = 1'b0;
  logic          stop = 1'b0;
  logic [AW-1:0] address;
  logic [CW-1:0] beat;
  logic          last, busy, done, wrapped, err;
  state_e        dbg_state;

  int vectors = 0;
  int miscompares = 0;
  int hold_addr = 0;
  int hold_beat = 0;

  always #5 clk = ~clk;

  addr_gen #(.ADDR_W(AW), .CNT_W(CW), .STEP_W(SW)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .cfg_base  (cfg_base),
    .cfg_limit (cfg_limit),
    .cfg_step  (cfg_step),
    .cfg_down  (cfg_down),
    .cfg_wrap  (cfg_wrap),
    .cnt_en    (cnt_en),
    .stop      (stop),
    .address   (address),
    .beat      (beat),
    .last      (last),
    .busy      (busy),
    .done      (done),
    .wrapped   (wrapped),
    .err       (err),
    .dbg_state (dbg_state)
  );

  // Address of beat k: base +/- k*step, reduced modulo 2^AW.
  function automatic logic [AW-1:0] exp_addr(input int b, input int s, input int d, input int k);
    int v;
    v = d ? (b - k * s) : (b + k * s);
    return v[AW-1:0];
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic scramble_cfg();
    cfg_base  = AW'($urandom_range(0, 255));
    cfg_limit = CW'($urandom_range(0, 20));
    cfg_step  = SW'($urandom_range(0, 15));
    cfg_down  = 1'($urandom_range(0, 1));
    cfg_wrap  = 1'($urandom_range(0, 1));
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    vectors++;
    if ({address, beat} !== {AW'(0), CW'(0)}) begin
      miscompares++;
      $display("FAIL reset_addr_beat: got addr=%0h beat=%0d, want 0/0", address, beat);
    end
    vectors++;
    if ({busy, last, done, wrapped, err} !== 5'b0 || dbg_state !== IDLE) begin
      miscompares++;
      $display("FAIL reset_flags: got busy/last/done/wrapped/err=%b state=%0d, want 00000/IDLE",
               {busy, last, done, wrapped, err}, dbg_state);
    end
    rst = 1'b0;
    tick();
    hold_addr = 0;
    hold_beat = 0;
  endtask

  // One-shot sweep; cfg and start are scrambled during RUN and start is
  // pulsed during DONE, none of which may disturb the sequence.
  task automatic test_oneshot(input int b, input int s, input int d, input int l, input bit gapped);
    int  k;
    bit  en;
    bit  finished;
    cfg_base = AW'(b); cfg_step = SW'(s); cfg_down = d[0]; cfg_limit = CW'(l); cfg_wrap = 1'b0;
    stop = 1'b0; cnt_en = 1'b0; start = 1'b1;
    tick();
    start = 1'b0;
    k = 0;
    finished = 1'b0;
    for (int c = 0; c < l * 8 + 20 && !finished; c++) begin
      vectors++;
      if (address !== exp_addr(b, s, d, k) || beat !== CW'(k)) begin
        miscompares++;
        $display("FAIL oneshot_seq: beat %0d got addr=%0h beat=%0d, want addr=%0h", k, address, beat,
                 exp_addr(b, s, d, k));
      end
      vectors++;
      if ({busy, last, done, wrapped, err} !== {1'b1, (k == l - 1), 3'b000}) begin
        miscompares++;
        $display("FAIL oneshot_flags: beat %0d got busy/last/done/wrapped/err=%b, want %b", k,
                 {busy, last, done, wrapped, err}, {1'b1, (k == l - 1), 3'b000});
      end
      en = gapped ? 1'($urandom_range(0, 1)) : 1'b1;
      cnt_en = en;
      start = 1'($urandom_range(0, 1));
      scramble_cfg();
      tick();
      if (en) begin
        if (k == l - 1) finished = 1'b1;
        else k++;
      end
    end
    vectors++;
    if (!finished) begin
      miscompares++;
      $display("FAIL oneshot_budget: sweep did not reach beat %0d, stuck at %0d", l - 1, k);
    end
    cnt_en = 1'b0;
    vectors++;
    if ({busy, done, address, beat} !== {1'b0, 1'b1, exp_addr(b, s, d, l - 1), CW'(l - 1)}) begin
      miscompares++;
      $display("FAIL oneshot_done: got busy=%b done=%b addr=%0h beat=%0d, want 0 1 %0h %0d", busy, done,
               address, beat, exp_addr(b, s, d, l - 1), l - 1);
    end
    start = 1'b1;
    cfg_limit = CW'($urandom_range(1, 5));
    tick();
    start = 1'b0;
    vectors++;
    if ({busy, done, last} !== 3'b000) begin
      miscompares++;
      $display("FAIL oneshot_after_done: got busy/done/last=%b, want 000", {busy, done, last});
    end
    tick();
    vectors++;
    if ({busy, done, address} !== {2'b00, exp_addr(b, s, d, l - 1)}) begin
      miscompares++;
      $display("FAIL start_in_done_ignored: got busy=%b done=%b addr=%0h, want 0 0 %0h", busy, done,
               address, exp_addr(b, s, d, l - 1));
    end
    hold_addr = int'(exp_addr(b, s, d, l - 1));
    hold_beat = l - 1;
  endtask

  // Wrap-mode run of `passes` passes, aborted with stop+cnt_en on the final beat.
  task automatic test_wrap_stop(input int b, input int s, input int d, input int l, input int passes);
    int n;
    int k;
    cfg_base = AW'(b); cfg_step = SW'(s); cfg_down = d[0]; cfg_limit = CW'(l); cfg_wrap = 1'b1;
    stop = 1'b0; cnt_en = 1'b0; start = 1'b1;
    tick();
    start = 1'b0;
    n = passes * l - 1;
    for (int j = 0; j <= n; j++) begin
      k = j % l;
      vectors++;
      if (address !== exp_addr(b, s, d, k) || beat !== CW'(k)) begin
        miscompares++;
        $display("FAIL wrap_seq: step %0d got addr=%0h beat=%0d, want addr=%0h beat=%0d", j, address, beat,
                 exp_addr(b, s, d, k), k);
      end
      vectors++;
      if ({busy, last, done, wrapped} !== {1'b1, (k == l - 1), 1'b0, (j > 0 && k == 0)}) begin
        miscompares++;
        $display("FAIL wrap_flags: step %0d got busy/last/done/wrapped=%b, want %b", j,
                 {busy, last, done, wrapped}, {1'b1, (k == l - 1), 1'b0, (j > 0 && k == 0)});
      end
      if (j < n) begin
        cnt_en = 1'b1;
        scramble_cfg();
        tick();
      end
    end
    stop = 1'b1;
    cnt_en = 1'b1;
    tick();
    stop = 1'b0;
    cnt_en = 1'b0;
    vectors++;
    if ({busy, done, wrapped, address, beat} !== {3'b000, exp_addr(b, s, d, l - 1), CW'(l - 1)}) begin
      miscompares++;
      $display("FAIL stop_abort: got busy/done/wrapped=%b addr=%0h beat=%0d, want 000 %0h %0d",
               {busy, done, wrapped}, address, beat, exp_addr(b, s, d, l - 1), l - 1);
    end
    tick();
    vectors++;
    if ({busy, done, wrapped} !== 3'b000) begin
      miscompares++;
      $display("FAIL stop_no_done: got busy/done/wrapped=%b, want 000", {busy, done, wrapped});
    end
    hold_addr = int'(exp_addr(b, s, d, l - 1));
    hold_beat = l - 1;
  endtask

  task automatic test_illegal_start();
    scramble_cfg();
    cfg_limit = '0;
    start = 1'b1;
    tick();
    start = 1'b0;
    vectors++;
    if ({err, busy, address, beat} !== {2'b10, AW'(hold_addr), CW'(hold_beat)}) begin
      miscompares++;
      $display("FAIL illegal_start: got err=%b busy=%b addr=%0h beat=%0d, want 1 0 %0h %0d", err, busy,
               address, beat, hold_addr, hold_beat);
    end
    tick();
    vectors++;
    if ({err, busy} !== 2'b00) begin
      miscompares++;
      $display("FAIL err_one_cycle: got err=%b busy=%b, want 0 0", err, busy);
    end
  endtask

  task automatic test_async_reset();
    int b, s;
    b = $urandom_range(0, 255);
    s = $urandom_range(1, 15);
    cfg_base = AW'(b); cfg_step = SW'(s); cfg_down = 1'b0; cfg_limit = CW'(8); cfg_wrap = 1'b0;
    start = 1'b1;
    tick();
    start = 1'b0;
    cnt_en = 1'b1;
    tick();
    tick();
    vectors++;
    if ({address, beat, busy} !== {exp_addr(b, s, 0, 2), CW'(2), 1'b1}) begin
      miscompares++;
      $display("FAIL pre_reset_beat2: got addr=%0h beat=%0d busy=%b, want %0h 2 1", address, beat, busy,
               exp_addr(b, s, 0, 2));
    end
    #2;
    rst = 1'b1;
    #1;
    vectors++;
    if ({address, beat, busy, done, last} !== {AW'(0), CW'(0), 3'b000} || dbg_state !== IDLE) begin
      miscompares++;
      $display("FAIL async_reset: got addr=%0h beat=%0d busy/done/last=%b state=%0d, want 0 0 000 IDLE",
               address, beat, {busy, done, last}, dbg_state);
    end
    cnt_en = 1'b0;
    tick();
    rst = 1'b0;
    tick();
    vectors++;
    if ({busy, done, address} !== {2'b00, AW'(0)}) begin
      miscompares++;
      $display("FAIL post_reset_idle: got busy=%b done=%b addr=%0h, want 0 0 0", busy, done, address);
    end
    hold_addr = 0;
    hold_beat = 0;
  endtask

  initial begin
    test_reset();
    test_oneshot(8'h10, 2, 0, 4, 1'b0);
    test_oneshot(8'h01, 3, 1, 3, 1'b0);
    test_wrap_stop(8'h20, 1, 0, 2, 2);
    test_illegal_start();
    test_oneshot($urandom_range(0, 255), $urandom_range(0, 15), $urandom_range(0, 1), 1, 1'b0);
    test_oneshot($urandom_range(0, 255), $urandom_range(0, 15), $urandom_range(0, 1), 6, 1'b1);
    test_oneshot($urandom_range(0, 255), 0, 0, 3, 1'b0);
    for (int i = 0; i < 4; i++) begin
      test_oneshot($urandom_range(0, 255), $urandom_range(0, 15), $urandom_range(0, 1),
                   $urandom_range(1, 12), 1'($urandom_range(0, 1)));
    end
    test_wrap_stop($urandom_range(0, 255), $urandom_range(1, 15), 1, $urandom_range(1, 5), 3);
    test_async_reset();
    test_illegal_start();
    test_oneshot($urandom_range(0, 255), $urandom_range(0, 15), $urandom_range(0, 1), 5, 1'b0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
